alu_bitserial_32: RTL
=====================

ALU_BITSERIAL_32 -- requirements
Module: alu_bitserial_32

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; only 32 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 src1  input  32  operand A; latched on accepted start.
REQ-006 src2  input  32  operand B; latched on accepted start.
REQ-007 ALU_control  input  4  operation code; latched on accepted start; bit3=Ainvert, bit2=Binvert, bits[1:0]=operation.
REQ-008 busy  output  1  high while the operation is in progress (RUN).
REQ-009 done  output  1  one-cycle pulse when result and flags are valid.
REQ-010 result  output  32  operation result; held until next accepted start or reset.
REQ-011 zero  output  1  result==0; held with result.
REQ-012 cout  output  1  carry out of bit 31 for ADD/SUB/SLT, else 0.
REQ-013 overflow  output  1  signed overflow for ADD/SUB/SLT, else 0.

Function
REQ-014 Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0111 SLT; any other code is executed per its control bits, with no error signalled.
REQ-015 FSM states: IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after bit 31 is processed, DONE->IDLE unconditionally after one cycle.
REQ-016 On the start edge in IDLE: latch src1, src2 and ALU_control; clear bit counter to 0; load carry flop with Binvert.
REQ-017 Each RUN cycle processes bit i=counter through one 1-bit slice, writes carry-out to the carry flop, shifts the slice result in at result MSB (result <= {bit, result[31:1]}), and increments the counter.
REQ-018 Exactly 32 RUN cycles: done is high in the cycle after the 32nd RUN edge, i.e. 33 cycles after the start edge; busy is high for exactly 32 cycles.
REQ-019 On the bit-31 edge: cout = slice carry-out; overflow = carry-in(31) XOR carry-out(31); both are forced to 0 when operation != 10/11.
REQ-020 SLT: the slice less input is 0 for all bits; on the bit-31 edge result is overwritten with {31'b0, set}, where set = sum(31) XOR overflow.
REQ-021 zero is computed from the final result value and updated on the same edge as result.
REQ-022 start is ignored in RUN and DONE; src1, src2 and ALU_control changes after acceptance have no effect.
REQ-023 Counter wrap from 31 to 0 is not observable: the FSM leaves RUN on the same edge.
REQ-024 Back-to-back operation: start held high is next accepted in the IDLE cycle following DONE.

Reset
REQ-025 rst asserted at any time forces IDLE, counter=0, carry=0, busy=0, done=0, result=0, zero=0, cout=0, overflow=0, asynchronously.
REQ-026 rst mid-RUN discards the operation; no done pulse is produced for it.

Structure
REQ-027 Shared package alu_pkg holds WIDTH, the six ALU_control code constants, and the FSM state type.
REQ-028 One instance of the existing alu_1bit slice performs the per-bit computation; the FSM, counter, carry flop, shift register and flags live in alu_bitserial_32.

Verification
REQ-029 ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, overflow 1, cout 0, zero 0, done 33 cycles after start.
REQ-030 SUB 0x00000005-0x00000005 -> result 0, zero 1, cout 1, overflow 0.
REQ-031 SLT 0xFFFFFFFF vs 0x00000001 -> result 1; SLT 0x7FFFFFFF vs 0x80000000 -> result 0, overflow 1.
REQ-032 NOR 0 with 0 -> 0xFFFFFFFF; AND 0xF0F0F0F0 with 0xFF00FF00 -> 0xF000F000, cout 0, overflow 0.
REQ-033 rst pulsed at counter=10 -> all outputs 0 immediately; no done pulse; a following ADD 3+4 returns 7.
REQ-034 start re-pulsed and src1/src2 changed mid-RUN -> ignored; original result is returned; done pulses exactly once.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the bit-serial ALU: width, operation codes, FSM states.
package alu_pkg;
   localparam int WIDTH = 32;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice: optional operand inversion, AND/OR/full-add/less select.
// Purely combinational; the raw adder sum is exported so the caller can form SLT.
module alu_1bit (
   input  logic       a,
   input  logic       b,
   input  logic       ainvert,
   input  logic       binvert,
   input  logic       cin,
   input  logic       less,
   input  logic [1:0] op,
   output logic       result,
   output logic       cout,
   output logic       sum
);
   logic a_eff;
   logic b_eff;

   assign a_eff = a ^ ainvert;
   assign b_eff = b ^ binvert;
   assign sum   = a_eff ^ b_eff ^ cin;
   assign cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);

   always_comb begin
      result = 1'b0;
      case (op)
         2'b00:   result = a_eff & b_eff;
         2'b01:   result = a_eff | b_eff;
         2'b10:   result = sum;
         default: result = less;
      endcase
   end
endmodule

// File: rtl/alu_bitserial_32.sv
// Bit-serial 32-bit ALU: one slice evaluated per cycle, LSB first, result shifted in at the MSB.
// Latency: 32 RUN cycles after the accepting edge, then a one-cycle done pulse.
module alu_bitserial_32 #(
   parameter int WIDTH = alu_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [3:0]       ALU_control,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout,
   output logic             overflow
);
   import alu_pkg::*;

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [3:0]       ctrl_q;
   logic [CW-1:0]    cnt;
   logic             carry;

   logic             slice_res;
   logic             slice_cout;
   logic             slice_sum;
   logic             last_bit;
   logic             arith;
   logic             ovf_bit;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] final_res;

   alu_1bit u_slice (
      .a       (a_q[cnt]),
      .b       (b_q[cnt]),
      .ainvert (ctrl_q[3]),
      .binvert (ctrl_q[2]),
      .cin     (carry),
      .less    (1'b0),
      .op      (ctrl_q[1:0]),
      .result  (slice_res),
      .cout    (slice_cout),
      .sum     (slice_sum)
   );

   assign last_bit = (cnt == CW'(WIDTH - 1));
   assign arith    = ctrl_q[1];
   assign ovf_bit  = carry ^ slice_cout;
   assign shifted  = {slice_res, result[WIDTH-1:1]};
   // SLT discards the shifted-in zeros and keeps only the corrected sign.
   assign final_res = (ctrl_q[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, slice_sum ^ ovf_bit}
                                             : shifted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         zero     <= 1'b0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q    <= src1;
                  b_q    <= src2;
                  ctrl_q <= ALU_control;
                  cnt    <= '0;
                  carry  <= ALU_control[2];
                  busy   <= 1'b1;
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               carry <= slice_cout;
               cnt   <= cnt + 1'b1;
               if (last_bit) begin
                  result   <= final_res;
                  zero     <= (final_res == '0);
                  cout     <= arith ? slice_cout : 1'b0;
                  overflow <= arith ? ovf_bit : 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  result <= shifted;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
